// File: rtl/cic_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cic_pkg : sizing helpers shared by the CIC up/down samplers       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package cic_pkg;

  function automatic int cic_pow(input int base, input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * base;
    return p;
  endfunction

  function automatic int cic_gain(input int r, input int m, input int n);
    return cic_pow(r * m, n) / r;
  endfunction

  // Interpolators lose one factor of R to zero stuffing; decimators keep it.
  function automatic int cic_dw(input int w, input int r, input int m, input int n, input bit up);
    return up ? (w + $clog2(cic_gain(r, m, n))) : (w + $clog2(cic_pow(r * m, n)));
  endfunction

  function automatic longint cic_attn(input int dw, input int gain);
    return (longint'(1) << (dw - 1)) / longint'(gain);
  endfunction

  localparam int GAIN = cic_gain(4, 2, 2);

endpackage
`default_nettype wire

// File: rtl/cic_upsampler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cic_upsampler_if : strobes and data of the CIC interpolator       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface cic_upsampler_if #(
  parameter int W  = 10,
  parameter int PW = 2
);
  logic                eni;
  logic                eno;
  logic signed [W-1:0] in;
  logic signed [W-1:0] out;
  logic [PW-1:0]       phase;
  logic                ovf;

  modport master (output eni, eno, in, input out, phase, ovf);
  modport slave  (input eni, eno, in, output out, phase, ovf);
endinterface
`default_nettype wire

// File: rtl/cic_comb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cic_comb : one comb stage, y <= x - x delayed by M enabled ticks  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module cic_comb #(
  parameter int DW = 14,
  parameter int M  = 2
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 en,
  input  wire logic signed [DW-1:0] x,
  output logic signed [DW-1:0]      y
);
  logic signed [DW-1:0] r_dly [0:M-1];
  logic signed [DW-1:0] r_y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < M; i++) r_dly[i] <= '0;
      r_y <= '0;
    end else if (en) begin
      r_y      <= x - r_dly[M-1];
      r_dly[0] <= x;
      for (int i = 1; i < M; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign y = r_y;
endmodule
`default_nettype wire

// File: rtl/cic_integrator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cic_integrator : one wrapping integrator stage                    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module cic_integrator #(
  parameter int DW = 14
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 en,
  input  wire logic signed [DW-1:0] x,
  output logic signed [DW-1:0]      y
);
  logic signed [DW-1:0] r_acc;

  // Modulo 2**DW wrap is what makes the comb/integrator pair exact.
  always_ff @(posedge clk) begin
    if (!rst_n)  r_acc <= '0;
    else if (en) r_acc <= r_acc + x;
  end

  assign y = r_acc;
endmodule
`default_nettype wire

// File: rtl/cic_zero_stuffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cic_zero_stuffer : low-to-high rate hand-over with overrun flag   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module cic_zero_stuffer #(
  parameter int DW = 14,
  parameter int R  = 4,
  parameter int PW = (R > 1) ? $clog2(R) : 1
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 eni,
  input  wire logic                 eno,
  input  wire logic signed [DW-1:0] x,
  output logic signed [DW-1:0]      y,
  output logic [PW-1:0]             phase,
  output logic                      ovf
);
  logic signed [DW-1:0] r_hold;
  logic signed [DW-1:0] r_y;
  logic                 r_pend;
  logic [PW-1:0]        r_phase;
  logic                 r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold  <= '0;
      r_y     <= '0;
      r_pend  <= 1'b0;
      r_phase <= '0;
      r_ovf   <= 1'b0;
    end else begin
      // eno always sees the pre-edge hold/pend, so a coincident eni is deferred.
      if (eno) begin
        r_y <= r_pend ? r_hold : '0;
        if (r_pend)                    r_phase <= '0;
        else if (r_phase != PW'(R-1))  r_phase <= r_phase + PW'(1);
      end
      if (eni) begin
        r_hold <= x;
        if (r_pend && !eno) r_ovf <= 1'b1;
      end
      if (eni)      r_pend <= 1'b1;
      else if (eno) r_pend <= 1'b0;
    end
  end

  assign y     = r_y;
  assign phase = r_phase;
  assign ovf   = r_ovf;
endmodule
`default_nettype wire

// File: rtl/cic_upsampler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cic_upsampler : N-stage CIC interpolator with gain correction     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module cic_upsampler
  import cic_pkg::*;
#(
  parameter int W = 10,
  parameter int R = 4,
  parameter int M = 2,
  parameter int N = 2
) (
  input wire logic       clk,
  input wire logic       rst_n,
  cic_upsampler_if.slave bus
);
  localparam int c_DW   = cic_dw(W, R, M, N, 1'b1);
  localparam int c_GAIN = cic_gain(R, M, N);
  localparam int c_PW   = (R > 1) ? $clog2(R) : 1;
  localparam logic signed [2*c_DW-1:0] c_ATTN = (2*c_DW)'(cic_attn(c_DW, c_GAIN));

  logic signed [c_DW-1:0] w_comb  [0:N];
  logic signed [c_DW-1:0] w_integ [0:N];
  logic signed [W-1:0]    r_out;

  assign w_comb[0] = c_DW'(bus.in);

  generate
    for (genvar i = 0; i < N; i++) begin : g_comb
      cic_comb #(.DW(c_DW), .M(M)) u_comb (
        .clk(clk), .rst_n(rst_n), .en(bus.eni),
        .x(w_comb[i]), .y(w_comb[i+1])
      );
    end
  endgenerate

  cic_zero_stuffer #(.DW(c_DW), .R(R), .PW(c_PW)) u_stuffer (
    .clk(clk), .rst_n(rst_n), .eni(bus.eni), .eno(bus.eno),
    .x(w_comb[N]), .y(w_integ[0]), .phase(bus.phase), .ovf(bus.ovf)
  );

  generate
    for (genvar i = 0; i < N; i++) begin : g_integ
      cic_integrator #(.DW(c_DW)) u_integ (
        .clk(clk), .rst_n(rst_n), .en(bus.eno),
        .x(w_integ[i]), .y(w_integ[i+1])
      );
    end
  endgenerate

  // Q1.(DW-1) attenuation undoes the CIC DC gain; full 2*DW product before the shift.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_out <= '0;
    else if (bus.eno) r_out <= W'(((2*c_DW)'(w_integ[N]) * c_ATTN) >>> (c_DW - 1));
  end

  assign bus.out = r_out;
endmodule
`default_nettype wire
